hashmap_arbiter: RTL and testbench
==================================

HASHMAP_ARBITER -- requirements
Module: hashmap_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter KEY_WIDTH, default 4, key width passed to the hashmap.
REQ-003 SHALL have parameter VALUE_WIDTH, default 4, value width passed to the hashmap.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_write  in  NUM_REQ  per-requester op: 1 = write, 0 = read.
REQ-008 SHALL have port req_key  in  NUM_REQ*KEY_WIDTH  packed keys; requester i occupies slice i.
REQ-009 SHALL have port req_value  in  NUM_REQ*VALUE_WIDTH  packed write values; requester i occupies slice i.
REQ-010 SHALL have port req_ready  out  NUM_REQ  one-hot grant; asserted in the accept cycle.
REQ-011 SHALL have port rsp_valid  out  NUM_REQ  one-hot response strobe to the granted requester.
REQ-012 SHALL have port rsp_hit, rsp_value, rsp_collision  out  1/VALUE_WIDTH/1  shared response payload.
REQ-013 SHALL have port clr_req  in  1  level request to clear the hashmap.
REQ-014 SHALL have port clr_done  out  1  one-cycle pulse when the clear has completed.
REQ-015 SHALL have ports hm_write_key/hm_write_value/hm_write_request/hm_read_key/hm_clear_cache  out  KEY_WIDTH/VALUE_WIDTH/1/KEY_WIDTH/1  hashmap drive.
REQ-016 SHALL have ports hm_collision/hm_read_value/hm_read_response  in  1/VALUE_WIDTH/1  hashmap status.
REQ-017 SHALL have port collision_count  out  16  write-collision statistic.

Function
REQ-018 SHALL implement FSM states IDLE, DRAIN and CLEAR, plus a round-robin pointer rr_ptr.
REQ-019 In IDLE with clr_req=0, SHALL grant at most one valid requester per cycle: the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-020 On a grant to requester g, SHALL set rr_ptr to (g+1) mod NUM_REQ in the next cycle; rr_ptr SHALL hold when there is no grant.
REQ-021 For a granted write, SHALL drive hm_write_request=1 with the key and value of g in the same cycle; hm_write_request SHALL otherwise be 0.
REQ-022 For a granted read, SHALL drive hm_read_key with the key of g in the same cycle; hm_read_key SHALL hold its last value otherwise.
REQ-023 SHALL register the response: in cycle N+1 after a grant in cycle N, rsp_valid[g]=1.
REQ-024 For a read response, rsp_hit SHALL equal the cycle-N hm_read_response, rsp_value the cycle-N hm_read_value, and rsp_collision SHALL be 0.
REQ-025 For a write response, rsp_hit SHALL be 1, rsp_collision SHALL equal the cycle-N hm_collision, and rsp_value SHALL be 0.
REQ-026 Whenever rsp_valid=0, all response payload outputs SHALL be 0.
REQ-027 Read-after-write: a read granted in the cycle after a write to the same key SHALL observe the new value (the hashmap updates at the clock edge).
REQ-028 With clr_req=1 in IDLE, SHALL issue no grant; SHALL go to DRAIN if a response is pending, otherwise to CLEAR.
REQ-029 DRAIN SHALL last exactly one cycle, deliver the pending response, then go to CLEAR.
REQ-030 CLEAR SHALL assert hm_clear_cache=1 for exactly one cycle, pulse clr_done in the following cycle, and return to IDLE.
REQ-031 SHALL not grant in DRAIN, CLEAR or the clr_done cycle; clr_req held high SHALL trigger another clear sequence.
REQ-032 req_valid=0 for all requesters SHALL produce no grant, no hashmap write, and no rsp_valid.

Reset
REQ-033 rst SHALL force IDLE and rr_ptr=0.
REQ-034 rst SHALL force req_ready, rsp_valid, rsp_hit, rsp_value, rsp_collision, clr_done, hm_write_request and hm_clear_cache to 0, and hm_read_key to 0.
REQ-035 rst mid-clear or with a response pending SHALL discard the operation; no rsp_valid or clr_done SHALL follow.
REQ-036 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-037 Macro HASHMAP_ARB_STATS_EN, when defined, SHALL make collision_count increment by 1 on each write response with rsp_collision=1.
REQ-038 With HASHMAP_ARB_STATS_EN defined, collision_count SHALL saturate at 0xFFFF and SHALL be zeroed by rst and by hm_clear_cache.
REQ-039 Without HASHMAP_ARB_STATS_EN, collision_count SHALL be tied to 0 and no counter logic SHALL be synthesized.

Verification
REQ-040 NUM_REQ=2; req0 writes key 3 / value 9, then reads key 3 -> cycle-1 rsp_valid=01, rsp_collision=0; read response rsp_hit=1, rsp_value=9.
REQ-041 req_valid=11 held 4 cycles -> req_ready sequence 01,10,01,10 starting with rr_ptr=0.
REQ-042 Write key 1, then write key 5 (hashmap CACHE_SIZE=4) -> second response rsp_collision=1; collision_count=1 with HASHMAP_ARB_STATS_EN, 0 without.
REQ-043 clr_req asserted in the cycle after a grant -> DRAIN delivers that response, hm_clear_cache pulses 1 cycle, clr_done follows; a subsequent read of key 3 returns rsp_hit=0.
REQ-044 rst asserted during CLEAR -> no clr_done and all outputs 0 next cycle; first grant after reset goes to req0.

Source files
------------

// File: rtl/hashmap_arbiter_if.sv
// hashmap_arbiter_if: requester-side request/response bus of hashmap_arbiter.
//   req_valid/req_write  per-requester valid and op (1 = write, 0 = read)
//   req_key/req_value    packed per-requester key and write value, slice i = requester i
//   req_ready            one-hot grant, asserted in the accept cycle
//   rsp_valid            one-hot response strobe, cycle after the grant
//   rsp_hit/rsp_value/rsp_collision  shared response payload (0 when rsp_valid = 0)
// master = requester side, slave = arbiter side.
interface hashmap_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int KEY_WIDTH   = 4,
  parameter int VALUE_WIDTH = 4
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key;
  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic                           rsp_hit;
  logic [VALUE_WIDTH-1:0]         rsp_value;
  logic                           rsp_collision;

  modport master (
    output req_valid, req_write, req_key, req_value,
    input  req_ready, rsp_valid, rsp_hit, rsp_value, rsp_collision
  );

  modport slave (
    input  req_valid, req_write, req_key, req_value,
    output req_ready, rsp_valid, rsp_hit, rsp_value, rsp_collision
  );
endinterface

// File: rtl/hashmap_arbiter.sv
// hashmap_arbiter: round-robin arbiter giving NUM_REQ requesters single-cycle
// access to one hashmap, with a drain/clear sequence on clr_req.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   bus (slave)         requester request/response bus (hashmap_arbiter_if)
//   clr_req / clr_done  level clear request / one-cycle completion pulse
//   hm_write_*          hashmap write drive (key, value, request strobe)
//   hm_read_key         hashmap read key (holds last read key between reads)
//   hm_clear_cache      one-cycle hashmap clear strobe
//   hm_collision, hm_read_value, hm_read_response  hashmap status inputs
//   collision_count     saturating write-collision counter
// Optional feature: define HASHMAP_ARB_STATS_EN to build the collision
// counter; otherwise collision_count is tied to 0.
module hashmap_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int KEY_WIDTH   = 4,
  parameter int VALUE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  hashmap_arbiter_if.slave       bus,
  input  logic                   clr_req,
  output logic                   clr_done,
  output logic [KEY_WIDTH-1:0]   hm_write_key,
  output logic [VALUE_WIDTH-1:0] hm_write_value,
  output logic                   hm_write_request,
  output logic [KEY_WIDTH-1:0]   hm_read_key,
  output logic                   hm_clear_cache,
  input  logic                   hm_collision,
  input  logic [VALUE_WIDTH-1:0] hm_read_value,
  input  logic                   hm_read_response,
  output logic [15:0]            collision_count
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t                 state_q;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic                   rsp_hit_q, rsp_col_q;
  logic [VALUE_WIDTH-1:0] rsp_value_q;
  logic                   clr_done_q, clr_q;
  logic [KEY_WIDTH-1:0]   rd_key_q;

  logic                   gnt_vld, gnt, gnt_wr;
  logic [PW-1:0]          gnt_idx;
  logic [NUM_REQ-1:0]     gnt_oh;
  logic [KEY_WIDTH-1:0]   gnt_key;
  logic [VALUE_WIDTH-1:0] gnt_val;
  int                     scan_idx;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!gnt_vld && bus.req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(scan_idx);
      end
    end
  end

  // No grants while clearing, in the clr_done cycle, on clr_req, or in reset.
  assign gnt     = gnt_vld && (state_q == IDLE) && !clr_req && !clr_done_q && !rst;
  assign gnt_wr  = bus.req_write[gnt_idx];
  assign gnt_key = bus.req_key[int'(gnt_idx)*KEY_WIDTH +: KEY_WIDTH];
  assign gnt_val = bus.req_value[int'(gnt_idx)*VALUE_WIDTH +: VALUE_WIDTH];
  assign gnt_oh  = gnt ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign rr_ptr_d = !gnt ? rr_ptr_q :
                    (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;

  assign bus.req_ready    = gnt_oh;
  assign hm_write_request = gnt && gnt_wr;
  assign hm_write_key     = gnt_key;
  assign hm_write_value   = gnt_val;
  // Read key is live on a read grant and otherwise holds the last read key.
  assign hm_read_key      = rst ? '0 : (gnt && !gnt_wr) ? gnt_key : rd_key_q;

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_hit       = rsp_hit_q;
  assign bus.rsp_value     = rsp_value_q;
  assign bus.rsp_collision = rsp_col_q;
  assign clr_done          = clr_done_q;
  assign hm_clear_cache    = clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_value_q <= '0;
      rsp_col_q   <= 1'b0;
      clr_done_q  <= 1'b0;
      clr_q       <= 1'b0;
      rd_key_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      // Payload is zeroed whenever no response is issued.
      rsp_valid_q <= gnt_oh;
      rsp_hit_q   <= gnt && (gnt_wr || hm_read_response);
      rsp_value_q <= (gnt && !gnt_wr) ? hm_read_value : '0;
      rsp_col_q   <= gnt && gnt_wr && hm_collision;
      if (gnt && !gnt_wr) rd_key_q <= gnt_key;
      clr_done_q  <= 1'b0;
      clr_q       <= 1'b0;
      case (state_q)
        IDLE: if (clr_req) begin
          // A response on the bus this cycle gets one drain cycle before the clear.
          if (|rsp_valid_q) state_q <= DRAIN;
          else begin
            state_q <= CLEAR;
            clr_q   <= 1'b1;
          end
        end
        DRAIN: begin
          state_q <= CLEAR;
          clr_q   <= 1'b1;
        end
        CLEAR: begin
          state_q    <= IDLE;
          clr_done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HASHMAP_ARB_STATS_EN
  // rsp_collision is only ever set on write responses.
  logic [15:0] coll_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_q)                          coll_cnt_q <= '0;
    else if (rsp_col_q && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
  end
  assign collision_count = coll_cnt_q;
`else
  assign collision_count = '0;
`endif
endmodule

// File: tb/tb_hashmap_arbiter.sv
module tb_hashmap_arbiter;
  localparam int NR = 2, KW = 4, VW = 4, CS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hashmap_arbiter_if #(.NUM_REQ(NR), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus();

  logic          clr_req = 1'b0;
  logic          clr_done;
  logic [KW-1:0] hm_write_key, hm_read_key;
  logic [VW-1:0] hm_write_value, hm_read_value;
  logic          hm_write_request, hm_clear_cache, hm_collision, hm_read_response;
  logic [15:0]   collision_count;

  hashmap_arbiter #(.NUM_REQ(NR), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .clr_req(clr_req), .clr_done(clr_done),
    .hm_write_key(hm_write_key), .hm_write_value(hm_write_value),
    .hm_write_request(hm_write_request), .hm_read_key(hm_read_key),
    .hm_clear_cache(hm_clear_cache), .hm_collision(hm_collision),
    .hm_read_value(hm_read_value), .hm_read_response(hm_read_response),
    .collision_count(collision_count)
  );

  // Direct-mapped hashmap stub, CACHE_SIZE = 4, indexed by key mod 4.
  logic [CS-1:0] st_vld;
  logic [KW-1:0] st_key [CS];
  logic [VW-1:0] st_val [CS];
  always @(posedge clk) begin
    if (rst) begin
      st_vld <= '0;
      for (int i = 0; i < CS; i++) begin st_key[i] <= '0; st_val[i] <= '0; end
    end else if (hm_clear_cache) st_vld <= '0;
    else if (hm_write_request) begin
      st_vld[hm_write_key[1:0]] <= 1'b1;
      st_key[hm_write_key[1:0]] <= hm_write_key;
      st_val[hm_write_key[1:0]] <= hm_write_value;
    end
  end
  assign hm_read_response = st_vld[hm_read_key[1:0]] && (st_key[hm_read_key[1:0]] == hm_read_key);
  assign hm_read_value    = st_val[hm_read_key[1:0]];
  assign hm_collision     = st_vld[hm_write_key[1:0]] && (st_key[hm_write_key[1:0]] != hm_write_key);

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: cycle index, scheduled clear/done cycles, expected response.
  int            t = 0, clr_at = -1, done_at = -1, ptr = 0, cnt = 0;
  logic [NR-1:0] e_rv = '0;
  logic          e_hit = 1'b0, e_col = 1'b0;
  logic [VW-1:0] e_val = '0;
  logic [KW-1:0] last_rk = '0;

  task automatic model_reset();
    clr_at = -1; done_at = -1; ptr = 0; cnt = 0;
    e_rv = '0; e_hit = 1'b0; e_col = 1'b0; e_val = '0; last_rk = '0;
  endtask

  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] w,
                      input logic [NR*KW-1:0] k, input logic [NR*VW-1:0] d, input logic c);
    int g;
    logic [KW-1:0] kg;
    logic [VW-1:0] dg;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = v; bus.req_write = w; bus.req_key = k; bus.req_value = d; clr_req = c;
    #1;
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("rsp_hit", bus.rsp_hit, e_hit);
    chk("rsp_value", bus.rsp_value, e_val);
    chk("rsp_coll", bus.rsp_collision, e_col);
    chk("clr_done", clr_done, t == done_at);
    chk("clear", hm_clear_cache, t == clr_at);
    chk("coll_cnt", collision_count, cnt);
    g = -1;
    if (t > clr_at && !c && t != done_at)
      for (int i = 0; i < NR; i++)
        if (g < 0 && v[(ptr + i) % NR]) g = (ptr + i) % NR;
    // Counter update at this edge (responses never coincide with the clear cycle).
`ifdef HASHMAP_ARB_STATS_EN
    if (t == clr_at) cnt = 0;
    else if (e_col && cnt < 16'hFFFF) cnt++;
`endif
    if (t > clr_at && c) begin
      clr_at  = t + ((e_rv != 0) ? 2 : 1);
      done_at = clr_at + 1;
    end
    chk("ready", bus.req_ready, (g >= 0) ? (1 << g) : 0);
    chk("wr_req", hm_write_request, (g >= 0) && w[g]);
    e_rv = '0; e_hit = 1'b0; e_col = 1'b0; e_val = '0;
    if (g >= 0) begin
      kg = k[g*KW +: KW];
      dg = d[g*VW +: VW];
      e_rv = NR'(1) << g;
      if (w[g]) begin
        chk("wr_key", hm_write_key, kg);
        chk("wr_val", hm_write_value, dg);
        chk("rd_key_hold", hm_read_key, last_rk);
        e_hit = 1'b1;
        e_col = st_vld[kg % CS] && (st_key[kg % CS] != kg);
      end else begin
        chk("rd_key", hm_read_key, kg);
        last_rk = kg;
        e_hit = st_vld[kg % CS] && (st_key[kg % CS] == kg);
        e_val = st_val[kg % CS];
      end
      ptr = (g + 1) % NR;
    end else chk("rd_key_hold", hm_read_key, last_rk);
    t++;
  endtask

  task automatic op(input int r, input bit wr, input int k, input int d, input bit c);
    logic [NR-1:0]    v;
    logic [NR*KW-1:0] kk;
    logic [NR*VW-1:0] dd;
    v = NR'(1) << r; kk = '0; dd = '0;
    kk[r*KW +: KW] = KW'(k);
    dd[r*VW +: VW] = VW'(d);
    step(v, wr ? v : '0, kk, dd, c);
  endtask

  task automatic idle(input bit c);
    step('0, '0, '0, '0, c);
  endtask

  // Reset with every other input asserted, to show reset takes priority.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; bus.req_valid = '1; bus.req_write = '1; clr_req = 1'b1;
      bus.req_key = '1; bus.req_value = '1;
      #1;
      if (i == 0) begin
        chk("rst_clear_in", hm_clear_cache, t == clr_at);
        chk("rst_done_in", clr_done, t == done_at);
      end
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_wr_req", hm_write_request, 0);
      chk("rst_rd_key", hm_read_key, 0);
      t++;
    end
    model_reset();
  endtask

  logic [NR-1:0] seq041 [4];

  initial begin
    bus.req_valid = '0; bus.req_write = '0; bus.req_key = '0; bus.req_value = '0;
    do_reset(3);

    // Write key 3 / value 9 then read it back on requester 0.
    op(0, 1, 3, 9, 0);
    op(0, 0, 3, 0, 0);
    chk("r40_rsp_valid", bus.rsp_valid, 2'b01);
    chk("r40_coll", bus.rsp_collision, 0);
    idle(0);
    chk("r40_hit", bus.rsp_hit, 1);
    chk("r40_val", bus.rsp_value, 9);

    // Both requesters held valid from rr_ptr = 0 alternate grants.
    do_reset(1);
    seq041[0] = 2'b01; seq041[1] = 2'b10; seq041[2] = 2'b01; seq041[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 2'b00, NR*KW'($urandom), NR*VW'($urandom), 0);
      chk("r41_ready", bus.req_ready, seq041[i]);
    end
    idle(0);

    // Key 1 then key 5 share slot 1.
    do_reset(1);
    op(0, 1, 1, 4, 0);
    op(0, 1, 5, 6, 0);
    idle(0);
    chk("r42_coll", bus.rsp_collision, 1);
    idle(0);
`ifdef HASHMAP_ARB_STATS_EN
    chk("r42_cnt", collision_count, 1);
`else
    chk("r42_cnt", collision_count, 0);
`endif

    // Clear requested in the cycle after a grant: drain, clear, done, then miss.
    op(0, 1, 3, 9, 0);
    idle(1);
    chk("r43_drain_rsp", bus.rsp_valid, 2'b01);
    op(0, 0, 3, 0, 0);
    op(0, 0, 3, 0, 0);
    chk("r43_clear", hm_clear_cache, 1);
    op(0, 0, 3, 0, 0);
    chk("r43_done", clr_done, 1);
    chk("r43_done_nogrant", bus.req_ready, 0);
    op(0, 0, 3, 0, 0);
    idle(0);
    chk("r43_miss", bus.rsp_hit, 0);

    // Reset during CLEAR discards the clear; first grant then goes to req0.
    idle(1);
    do_reset(1);
    idle(0);
    chk("r44_done", clr_done, 0);
    chk("r44_rsp", bus.rsp_valid, 0);
    step(2'b11, 2'b00, '0, '0, 0);
    chk("r44_first", bus.req_ready, 2'b01);

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      logic [NR*KW-1:0] kk;
      logic [NR*VW-1:0] dd;
      for (int r = 0; r < NR; r++) begin
        kk[r*KW +: KW] = KW'($urandom_range(0, 7));
        dd[r*VW +: VW] = VW'($urandom);
      end
      if ($urandom_range(0, 79) == 0) do_reset(1);
      else step(NR'($urandom), NR'($urandom), kk, dd, $urandom_range(0, 11) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
